// File: rtl/pulse_sched_pkg.sv
// Shared types and constants for the pulse job scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pulse_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_GAP
  } state_t;

  // Job word layout: [6:0] start, [13:7] end, [21:14] loop count, [31:22] gap
  localparam int JOB_W       = 32;
  localparam int START_LSB   = 0;
  localparam int END_LSB     = 7;
  localparam int IDX_W       = 7;
  localparam int LOOP_LSB    = 14;
  localparam int LOOP_W      = 8;
  localparam int GAP_LSB     = 22;
  localparam int GAP_FIELD_W = 10;

  // Cycles allowed in WAIT_ACK for the transmitter to raise busy
  localparam int ACK_TIMEOUT = 15;
  localparam int ACK_CNT_W   = 4;

  // Packed view of the job word; the first member occupies the MSBs
  typedef struct packed {
    logic [GAP_FIELD_W-1:0] gap;
    logic [LOOP_W-1:0]      loop_cnt;
    logic [IDX_W-1:0]       end_idx;
    logic [IDX_W-1:0]       start_idx;
  } job_t;

endpackage

// File: rtl/pulse_job_fifo.sv
// Synchronous job queue with flush; head word is visible on dout without a read cycle.
// Latency: a push is visible at dout/count one cycle later.
// Backpressure: push while full is ignored unless a pop happens in the same cycle; flush beats both.
module pulse_job_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign full      = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = pop && (r_count != '0) && !flush;
  assign w_do_push = push && (!full || w_do_pop) && !flush;
  assign dout      = r_mem[r_rd_ptr];
  assign count     = r_count;

  // Storage: written only on an accepted push; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; simultaneous push+pop leaves count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/pulse_job_scheduler.sv
// Queues pulse jobs and launches them one at a time on the transmitter, with an inter-job gap.
// Latency: push into empty queue at N (enable=1) -> LOAD at N+1, tx_start at N+2.
// Backpressure: push while full is dropped (sticky overflow) unless LOAD pops that cycle; abort flushes.
module pulse_job_scheduler import pulse_sched_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int GAP_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            job_data,
  input  logic                   job_push,
  input  logic                   enable,
  input  logic                   abort,
  input  logic                   ovf_clear,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic                   tx_stop,
  output logic [6:0]             tx_start_index,
  output logic [6:0]             tx_end_index,
  output logic [7:0]             tx_loop_count,
  output logic [$clog2(DEPTH):0] job_count,
  output logic                   job_full,
  output logic                   active,
  output logic                   job_done,
  output logic                   overflow,
  output logic                   ack_err
);
  state_t                 r_state;
  logic [IDX_W-1:0]       r_start_idx;
  logic [IDX_W-1:0]       r_end_idx;
  logic [LOOP_W-1:0]      r_loop_cnt;
  logic [GAP_W-1:0]       r_gap;
  logic [GAP_W-1:0]       r_gap_cnt;
  logic [ACK_CNT_W-1:0]   r_ack_cnt;
  logic                   r_tx_stop;
  logic                   r_job_done;
  logic                   r_overflow;
  logic                   r_ack_err;

  logic [JOB_W-1:0]       w_head_dat;
  job_t                   w_head;
  logic                   w_pop;
  logic                   w_fifo_full;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_job_avail;
  logic                   w_ack_timeout;
  logic                   w_ovf_set;

  pulse_job_fifo #(.DEPTH(DEPTH), .W(JOB_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (job_push),
    .pop   (w_pop),
    .flush (abort),
    .din   (job_data),
    .dout  (w_head_dat),
    .full  (w_fifo_full),
    .count (w_count)
  );

  assign w_head = job_t'(w_head_dat);
  assign w_pop  = (r_state == ST_LOAD) && !abort;
  // A push this cycle counts as available so an empty-queue push reaches LOAD next cycle
  assign w_job_avail   = (w_count != '0) || job_push;
  assign w_ack_timeout = (r_state == ST_WAIT_ACK) && !tx_busy && !abort &&
                         (r_ack_cnt == ACK_CNT_W'(ACK_TIMEOUT - 1));
  assign w_ovf_set     = job_push && w_fifo_full && !w_pop && !abort;

  // start/active are decoded straight from the state flop so they carry no extra lag
  assign tx_start       = (r_state == ST_START);
  assign active         = (r_state != ST_IDLE);
  assign tx_stop        = r_tx_stop;
  assign job_done       = r_job_done;
  assign tx_start_index = r_start_idx;
  assign tx_end_index   = r_end_idx;
  assign tx_loop_count  = r_loop_cnt;
  assign job_count      = w_count;
  assign job_full       = w_fifo_full;
  assign overflow       = r_overflow;
  assign ack_err        = r_ack_err;

  // Job sequencer; job_done is raised one cycle early so it lands on the final GAP cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_start_idx <= '0;
      r_end_idx   <= '0;
      r_loop_cnt  <= '0;
      r_gap       <= '0;
      r_gap_cnt   <= '0;
      r_ack_cnt   <= '0;
      r_tx_stop   <= 1'b0;
      r_job_done  <= 1'b0;
    end else begin
      r_tx_stop  <= 1'b0;
      r_job_done <= 1'b0;
      if (abort) begin
        r_state   <= ST_IDLE;
        r_tx_stop <= (r_state == ST_WAIT_ACK) || (r_state == ST_WAIT_DONE);
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (enable && w_job_avail) r_state <= ST_LOAD;
          end
          ST_LOAD: begin
            r_start_idx <= w_head.start_idx;
            r_end_idx   <= w_head.end_idx;
            r_loop_cnt  <= w_head.loop_cnt;
            r_gap       <= GAP_W'(w_head.gap);
            r_state     <= ST_START;
          end
          ST_START: begin
            r_ack_cnt <= '0;
            r_state   <= ST_WAIT_ACK;
          end
          ST_WAIT_ACK: begin
            if (tx_busy) begin
              r_state <= ST_WAIT_DONE;
            end else if (w_ack_timeout) begin
              r_state    <= ST_GAP;
              r_gap_cnt  <= r_gap;
              r_job_done <= (r_gap == '0);
            end else begin
              r_ack_cnt <= r_ack_cnt + 1'b1;
            end
          end
          ST_WAIT_DONE: begin
            if (!tx_busy) begin
              r_state    <= ST_GAP;
              r_gap_cnt  <= r_gap;
              r_job_done <= (r_gap == '0);
            end
          end
          ST_GAP: begin
            if (r_gap_cnt == '0) begin
              r_state <= (enable && w_job_avail) ? ST_LOAD : ST_IDLE;
            end else begin
              r_gap_cnt  <= r_gap_cnt - 1'b1;
              r_job_done <= (r_gap_cnt == GAP_W'(1));
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Sticky error flags; a new error event wins over a coincident clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_ack_err  <= 1'b0;
    end else begin
      if (w_ovf_set)      r_overflow <= 1'b1;
      else if (ovf_clear) r_overflow <= 1'b0;
      if (w_ack_timeout)  r_ack_err  <= 1'b1;
      else if (ovf_clear) r_ack_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_job_scheduler.sv
// Directed bench for pulse_job_scheduler with hand-computed expectations.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Backpressure: bench plays the transmitter by driving tx_busy.
module tb_pulse_job_scheduler;
  logic        clk;
  logic        rst;
  logic [31:0] job_data;
  logic        job_push;
  logic        enable;
  logic        abort;
  logic        ovf_clear;
  logic        tx_busy;
  logic        tx_start;
  logic        tx_stop;
  logic [6:0]  tx_start_index;
  logic [6:0]  tx_end_index;
  logic [7:0]  tx_loop_count;
  logic [2:0]  job_count;
  logic        job_full;
  logic        active;
  logic        job_done;
  logic        overflow;
  logic        ack_err;

  int n_cmp = 0;
  int n_err = 0;

  pulse_job_scheduler #(.DEPTH(4), .GAP_W(10)) dut (
    .clk            (clk),
    .rst            (rst),
    .job_data       (job_data),
    .job_push       (job_push),
    .enable         (enable),
    .abort          (abort),
    .ovf_clear      (ovf_clear),
    .tx_busy        (tx_busy),
    .tx_start       (tx_start),
    .tx_stop        (tx_stop),
    .tx_start_index (tx_start_index),
    .tx_end_index   (tx_end_index),
    .tx_loop_count  (tx_loop_count),
    .job_count      (job_count),
    .job_full       (job_full),
    .active         (active),
    .job_done       (job_done),
    .overflow       (overflow),
    .ack_err        (ack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_job(input int s, input int e, input int l, input int g);
    return {g[9:0], l[7:0], e[6:0], s[6:0]};
  endfunction

  function automatic logic [31:0] all_outs();
    return {tx_start, tx_stop, tx_start_index, tx_end_index, tx_loop_count,
            job_count, job_full, active, job_done, overflow, ack_err};
  endfunction

  // Wait for a launch, check its config, act as transmitter, wait for job_done
  task automatic serve(input int exp_start, input int exp_loop);
    int n;
    n = 0;
    while (!tx_start && n < 64) begin tick(); n++; end
    chk("serve_start_seen", 32'(tx_start), 1);
    chk("serve_start_idx", 32'(tx_start_index), exp_start);
    chk("serve_loop_cnt", 32'(tx_loop_count), exp_loop);
    tick();
    tx_busy = 1'b1;
    repeat (3) tick();
    tx_busy = 1'b0;
    n = 0;
    while (!job_done && n < 64) begin tick(); n++; end
    chk("serve_done_seen", 32'(job_done), 1);
  endtask

  initial begin
    rst = 1'b1; job_data = '0; job_push = 1'b0; enable = 1'b0;
    abort = 1'b0; ovf_clear = 1'b0; tx_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs(), 0);
    @(negedge clk) rst = 1'b0;
    tick();

    // Single job, tx_busy high 3 cycles after tx_start for 20 cycles
    enable = 1'b1;
    job_data = 32'h0040_0F80; job_push = 1'b1;
    tick();
    job_push = 1'b0;
    chk("t1_load_active", 32'(active), 1);
    chk("t1_tx_start_early", 32'(tx_start), 0);
    tick();
    chk("t1_tx_start", 32'(tx_start), 1);
    chk("t1_start_idx", 32'(tx_start_index), 0);
    chk("t1_end_idx", 32'(tx_end_index), 31);
    chk("t1_count_after_pop", 32'(job_count), 0);
    tick();
    chk("t1_tx_start_one_cycle", 32'(tx_start), 0);
    tick(); tick();
    tx_busy = 1'b1;
    repeat (20) tick();
    tx_busy = 1'b0;
    tick();
    chk("t1_done_early", 32'(job_done), 0);
    tick();
    chk("t1_done", 32'(job_done), 1);
    tick();
    chk("t1_done_pulse_end", 32'(job_done), 0);
    chk("t1_idle", 32'(active), 0);
    chk("t1_end_idx_held", 32'(tx_end_index), 31);

    // Five pushes with enable low
    enable = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      job_data = mk_job(i, i + 10, i + 16, 2); job_push = 1'b1;
      tick();
      if (i == 4) chk("t2_ovf_before_fifth", 32'(overflow), 0);
    end
    job_push = 1'b0;
    chk("t2_count", 32'(job_count), 4);
    chk("t2_full", 32'(job_full), 1);
    chk("t2_overflow", 32'(overflow), 1);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    chk("t2_ovf_cleared", 32'(overflow), 0);

    // Push while full in the LOAD cycle is accepted
    enable = 1'b1;
    tick();
    chk("t3_in_load_count", 32'(job_count), 4);
    job_data = mk_job(9, 20, 99, 0); job_push = 1'b1;
    tick();
    job_push = 1'b0;
    chk("t3_count_kept", 32'(job_count), 4);
    chk("t3_full_kept", 32'(job_full), 1);
    chk("t3_no_overflow", 32'(overflow), 0);
    serve(1, 17);
    serve(2, 18);
    serve(3, 19);
    serve(4, 20);
    serve(9, 99);
    tick();
    chk("t3_drained_idle", 32'(active), 0);
    chk("t3_drained_count", 32'(job_count), 0);
    repeat (3) tick();
    chk("t3_fifth_never_launched", 32'(active), 0);

    // Ack timeout, then the next job launches
    job_data = mk_job(3, 40, 7, 0); job_push = 1'b1;
    tick();
    job_data = mk_job(6, 50, 8, 3);
    tick();
    job_push = 1'b0;
    chk("t4_start_a", 32'(tx_start), 1);
    chk("t4_start_a_idx", 32'(tx_start_index), 3);
    repeat (15) tick();
    chk("t4_no_ack_err_yet", 32'(ack_err), 0);
    tick();
    chk("t4_ack_err", 32'(ack_err), 1);
    chk("t4_gap0_done", 32'(job_done), 1);
    tick(); tick();
    chk("t4_start_b", 32'(tx_start), 1);
    chk("t4_start_b_idx", 32'(tx_start_index), 6);
    chk("t4_ack_err_sticky", 32'(ack_err), 1);

    // Abort in WAIT_DONE with two jobs queued
    tick();
    tx_busy = 1'b1;
    job_data = mk_job(11, 12, 13, 1); job_push = 1'b1;
    tick();
    job_data = mk_job(14, 15, 16, 1);
    tick();
    job_push = 1'b0;
    chk("t5_queued", 32'(job_count), 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_tx_stop", 32'(tx_stop), 1);
    chk("t5_flushed", 32'(job_count), 0);
    chk("t5_idle", 32'(active), 0);
    chk("t5_no_done", 32'(job_done), 0);
    tick();
    tx_busy = 1'b0;
    chk("t5_stop_one_cycle", 32'(tx_stop), 0);
    chk("t5_no_done_later", 32'(job_done), 0);

    // Overflow set wins over a coincident clear; clear still drops ack_err
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      job_data = mk_job(i, i, i, 0); job_push = 1'b1;
      tick();
    end
    ovf_clear = 1'b1;
    tick();
    job_push = 1'b0; ovf_clear = 1'b0;
    chk("t6_set_wins", 32'(overflow), 1);
    chk("t6_ack_err_cleared", 32'(ack_err), 0);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    job_push = 1'b1; abort = 1'b1;
    tick();
    job_push = 1'b0; abort = 1'b0;
    chk("t6_abort_push_no_ovf", 32'(overflow), 0);
    chk("t6_abort_flush", 32'(job_count), 0);

    // Asynchronous reset while in GAP
    enable = 1'b1;
    job_data = mk_job(5, 60, 33, 10); job_push = 1'b1;
    tick();
    job_data = mk_job(7, 8, 9, 1);
    tick();
    job_push = 1'b0;
    tick();
    tx_busy = 1'b1;
    tick();
    tx_busy = 1'b0;
    tick();
    chk("t7_in_gap", 32'(active), 1);
    chk("t7_queued", 32'(job_count), 1);
    chk("t7_idx_before", 32'(tx_start_index), 5);
    #2 rst = 1'b1;
    #1;
    chk("t7_async_reset_outputs", all_outs(), 0);
    @(negedge clk) rst = 1'b0;
    tick();
    chk("t7_queue_empty", 32'(job_count), 0);
    chk("t7_idle_after", 32'(active), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
